// File: rtl/i2s_burst_sched.sv
// Burst scheduler and APB master for the I2S transceiver data registers.
// Define I2S_SCHED_RX_PRIO_EN to give Rx fixed priority on ties.
module i2s_burst_sched #(
  parameter logic [31:0] TX_ADDR = 32'h0000_0000,
  parameter logic [31:0] RX_ADDR = 32'h0000_0004,
  parameter int          BURST   = 4
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        en,
  input  logic        tx_valid,
  input  logic [31:0] tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [31:0] rx_data,
  input  logic        rx_ready,
  input  logic        tx_al_empty,
  input  logic        tx_full,
  input  logic        rx_al_full,
  input  logic        rx_empty,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [31:0] m_paddr,
  output logic [31:0] m_pwdata,
  input  logic [31:0] m_prdata,
  output logic [1:0]  grant,
  output logic        busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] TX_LOAD   = 3'd1;
  localparam logic [2:0] TX_SETUP  = 3'd2;
  localparam logic [2:0] TX_ACCESS = 3'd3;
  localparam logic [2:0] RX_SETUP  = 3'd4;
  localparam logic [2:0] RX_ACCESS = 3'd5;
  localparam logic [2:0] RX_PUSH   = 3'd6;

  localparam logic [4:0] BURST_W = 5'(BURST);

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [4:0]  word_cnt;
  logic        last_rx;
  logic [1:0]  grant_q;
  logic [31:0] pwdata_q;
  logic [31:0] rxdata_q;

  logic tx_req;
  logic rx_req;
  logic pick_tx;
  logic pick_rx;
  logic tx_load;
  logic rx_done;
  logic rx_more;
  logic end_burst;

  assign tx_req = en & tx_al_empty & ~tx_full & tx_valid;
  assign rx_req = en & rx_al_full & ~rx_empty;

`ifdef I2S_SCHED_RX_PRIO_EN
  assign pick_rx = rx_req;
  assign pick_tx = tx_req & ~rx_req;
`else
  // last_rx set means Rx owned the port last, so Tx wins the tie
  assign pick_tx = tx_req & (~rx_req | last_rx);
  assign pick_rx = rx_req & ~pick_tx;
`endif

  assign tx_load = (state == TX_LOAD) & en & tx_valid & ~tx_full
                 & (word_cnt < BURST_W);
  assign rx_done = (state == RX_PUSH) & rx_ready;
  assign rx_more = en & ~rx_empty & ((word_cnt + 5'd1) < BURST_W);

  assign end_burst = ((state == TX_LOAD) & ~tx_load)
                   | (rx_done & ~rx_more);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (pick_tx)
          state_nx = TX_LOAD;
        else if (pick_rx)
          state_nx = RX_SETUP;
      end
      TX_LOAD:   state_nx = tx_load ? TX_SETUP : IDLE;
      TX_SETUP:  state_nx = TX_ACCESS;
      TX_ACCESS: state_nx = TX_LOAD;
      RX_SETUP:  state_nx = RX_ACCESS;
      RX_ACCESS: state_nx = RX_PUSH;
      RX_PUSH: begin
        if (rx_ready)
          state_nx = rx_more ? RX_SETUP : IDLE;
      end
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state    <= IDLE;
      word_cnt <= 5'd0;
      last_rx  <= 1'b1;
      grant_q  <= 2'b00;
      pwdata_q <= 32'd0;
      rxdata_q <= 32'd0;
    end else begin
      state <= state_nx;
      if (end_burst) begin
        word_cnt <= 5'd0;
        last_rx  <= grant_q[1];
        grant_q  <= 2'b00;
      end else if ((state == TX_ACCESS) | rx_done) begin
        word_cnt <= word_cnt + 5'd1;
      end
      if (state == IDLE) begin
        if (pick_tx)
          grant_q <= 2'b01;
        else if (pick_rx)
          grant_q <= 2'b10;
      end
      if (tx_load)
        pwdata_q <= tx_data;
      if (state == RX_ACCESS)
        rxdata_q <= m_prdata;
    end
  end

  assign tx_ready  = tx_load;
  assign rx_valid  = (state == RX_PUSH);
  assign rx_data   = rxdata_q;
  assign m_pwdata  = pwdata_q;
  assign m_penable = (state == TX_ACCESS) | (state == RX_ACCESS);
  assign m_pwrite  = (state == TX_SETUP) | (state == TX_ACCESS);
  assign grant     = grant_q;
  assign busy      = (state != IDLE);

  always_comb begin
    m_paddr = 32'd0;
    if ((state == TX_SETUP) | (state == TX_ACCESS))
      m_paddr = TX_ADDR;
    else if ((state == RX_SETUP) | (state == RX_ACCESS))
      m_paddr = RX_ADDR;
  end

endmodule

// File: tb/tb_i2s_burst_sched.sv
// Scoreboard bench for i2s_burst_sched with simple Tx source,
// Tx FIFO fill counter and Rx FIFO models.
module tb_i2s_burst_sched;

  localparam logic [31:0] TXA = 32'h0000_0000;
  localparam logic [31:0] RXA = 32'h0000_0004;

  logic        pclk = 1'b0;
  logic        preset;
  logic        en;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_ready;
  logic        tx_al_empty;
  logic        tx_full;
  logic        rx_al_full;
  logic        rx_empty;
  logic        m_penable;
  logic        m_pwrite;
  logic [31:0] m_paddr;
  logic [31:0] m_pwdata;
  logic [31:0] m_prdata;
  logic [1:0]  grant;
  logic        busy;

  i2s_burst_sched #(.TX_ADDR(TXA), .RX_ADDR(RXA), .BURST(4)) dut (
    .pclk(pclk), .preset(preset), .en(en),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_al_empty(tx_al_empty), .tx_full(tx_full),
    .rx_al_full(rx_al_full), .rx_empty(rx_empty),
    .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .grant(grant), .busy(busy)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none/in-time", name);
  endtask

  // Source, Tx FIFO and Rx FIFO models
  logic [31:0] src_mem [64];
  logic [31:0] rx_mem  [64];
  logic [5:0]  src_rd = 6'd0, src_wr = 6'd0;
  logic [5:0]  rx_rd = 6'd0, rx_wr = 6'd0;
  logic        src_flush = 1'b0, rx_flush = 1'b0;
  int          tx_cnt = 0;
  int          tx_lim = 1000;

  assign tx_valid = (src_rd != src_wr);
  assign tx_data  = src_mem[src_rd];
  assign rx_empty = (rx_rd == rx_wr);
  assign m_prdata = rx_mem[rx_rd];
  assign tx_full  = (tx_cnt >= tx_lim);

  always @(posedge pclk) begin
    if (src_flush) src_rd <= src_wr;
    else if (tx_ready) src_rd <= src_rd + 6'd1;
    if (rx_flush) rx_rd <= rx_wr;
    else if (m_penable && !m_pwrite) rx_rd <= rx_rd + 6'd1;
    if (m_penable && m_pwrite) tx_cnt <= tx_cnt + 1;
  end

  task automatic push_src(input logic [31:0] d);
    src_mem[src_wr] = d;
    src_wr = src_wr + 6'd1;
  endtask

  task automatic push_rx(input logic [31:0] d);
    rx_mem[rx_wr] = d;
    rx_wr = rx_wr + 6'd1;
  endtask

  // Scoreboard
  logic [31:0] exp_wr[$];
  logic [31:0] exp_rx[$];
  logic [1:0]  exp_grant[$];
  logic [1:0]  prev_grant = 2'b00;
  int cyc = 0, burst_id = 0, last_wr_cyc = 0, last_wr_burst = -1;
  int ready_cnt = 0;

  always @(negedge pclk) begin
    cyc++;
    if (grant != 2'b00 && grant != prev_grant) begin
      burst_id++;
      if (exp_grant.size() == 0) fail_now("grant_extra");
      else chk("grant", {30'd0, grant}, {30'd0, exp_grant.pop_front()});
    end
    prev_grant = grant;
    if (m_penable && m_pwrite) begin
      chk("wr_addr", m_paddr, TXA);
      if (exp_wr.size() == 0) fail_now("wr_extra");
      else chk("wr_data", m_pwdata, exp_wr.pop_front());
      if (last_wr_burst == burst_id)
        chk("wr_gap", cyc - last_wr_cyc, 3);
      last_wr_cyc = cyc;
      last_wr_burst = burst_id;
    end
    if (m_penable && !m_pwrite) begin
      chk("rd_addr", m_paddr, RXA);
      chk("rd_nonempty", {31'd0, rx_empty}, 32'd0);
    end
    if (rx_valid && rx_ready) begin
      if (exp_rx.size() == 0) fail_now("rx_extra");
      else chk("rx_data", rx_data, exp_rx.pop_front());
    end
    if (tx_ready) ready_cnt++;
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_quiet(input string name);
    int seen = 0;
    int quiet = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge pclk);
      if (busy) begin
        seen = 1;
        quiet = 0;
      end else begin
        quiet++;
      end
      if (seen != 0 && quiet >= 3) return;
    end
    fail_now({name, "_timeout"});
  endtask

  task automatic flush();
    step();
    src_flush = 1'b1;
    rx_flush = 1'b1;
    step();
    src_flush = 1'b0;
    rx_flush = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_penable"}, {31'd0, m_penable}, 32'd0);
    chk({tag, "_pwrite"}, {31'd0, m_pwrite}, 32'd0);
    chk({tag, "_paddr"}, m_paddr, 32'd0);
    chk({tag, "_pwdata"}, m_pwdata, 32'd0);
    chk({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    chk({tag, "_rx_data"}, rx_data, 32'd0);
    chk({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd0);
    chk({tag, "_grant"}, {30'd0, grant}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int rises;
    int r0;
    int ok;
    preset = 1'b1;
    en = 1'b0;
    rx_ready = 1'b0;
    tx_al_empty = 1'b0;
    rx_al_full = 1'b0;
    step();
    step();
    chk_zero("reset");
    preset = 1'b0;
    step();

    // Tx only burst
    for (int i = 1; i <= 4; i++) begin
      push_src(32'hA5A5_0000 + 32'(i));
      exp_wr.push_back(32'hA5A5_0000 + 32'(i));
    end
    exp_grant.push_back(2'b01);
    en = 1'b1;
    tx_al_empty = 1'b1;
    wait_quiet("tx_only");
    step();
    tx_al_empty = 1'b0;
    chk("tx_only_left", exp_wr.size(), 0);

    // Rx only, FIFO empties after two reads
    push_rx(32'h0000_1111);
    push_rx(32'h0000_2222);
    exp_rx.push_back(32'h0000_1111);
    exp_rx.push_back(32'h0000_2222);
    exp_grant.push_back(2'b10);
    rx_ready = 1'b1;
    rx_al_full = 1'b1;
    wait_quiet("rx_only");
    step();
    rx_al_full = 1'b0;
    chk("rx_only_left", exp_rx.size(), 0);

    // Tie between both requesters
    for (int i = 1; i <= 8; i++) push_src(32'hB000_0000 + 32'(i));
    for (int i = 1; i <= 12; i++) push_rx(32'hC000_0000 + 32'(i));
`ifdef I2S_SCHED_RX_PRIO_EN
    for (int i = 0; i < 3; i++) exp_grant.push_back(2'b10);
    for (int i = 1; i <= 12; i++) exp_rx.push_back(32'hC000_0000 + 32'(i));
`else
    exp_grant.push_back(2'b01);
    exp_grant.push_back(2'b10);
    exp_grant.push_back(2'b01);
    for (int i = 1; i <= 8; i++) exp_wr.push_back(32'hB000_0000 + 32'(i));
    for (int i = 1; i <= 4; i++) exp_rx.push_back(32'hC000_0000 + 32'(i));
`endif
    tx_al_empty = 1'b1;
    rx_al_full = 1'b1;
    rises = 0;
    begin
      logic [1:0] pg;
      pg = 2'b00;
      for (int i = 0; i < 400 && rises < 3; i++) begin
        @(negedge pclk);
        if (grant != 2'b00 && grant != pg) rises++;
        pg = grant;
      end
    end
    tx_al_empty = 1'b0;
    rx_al_full = 1'b0;
    if (rises < 3) fail_now("tie_timeout");
    wait_quiet("tie");
    flush();
    chk("tie_wr_left", exp_wr.size(), 0);
    chk("tie_rx_left", exp_rx.size(), 0);
    chk("tie_grant_left", exp_grant.size(), 0);

    // Rx backpressure
    push_rx(32'hD00D_0001);
    exp_rx.push_back(32'hD00D_0001);
    exp_grant.push_back(2'b10);
    rx_ready = 1'b0;
    rx_al_full = 1'b1;
    ok = 0;
    for (int i = 0; i < 40 && ok == 0; i++) begin
      @(negedge pclk);
      if (rx_valid) ok = 1;
    end
    if (ok == 0) fail_now("bp_timeout");
    rx_al_full = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, rx_valid}, 32'd1);
      chk("bp_data", rx_data, 32'hD00D_0001);
      chk("bp_penable", {31'd0, m_penable}, 32'd0);
      @(negedge pclk);
    end
    step();
    rx_ready = 1'b1;
    wait_quiet("bp");
    chk("bp_left", exp_rx.size(), 0);

    // Tx FIFO fills after two words
    step();
    r0 = ready_cnt;
    tx_lim = tx_cnt + 2;
    for (int i = 1; i <= 4; i++) push_src(32'hE000_0000 + 32'(i));
    exp_wr.push_back(32'hE000_0001);
    exp_wr.push_back(32'hE000_0002);
    exp_grant.push_back(2'b01);
    tx_al_empty = 1'b1;
    wait_quiet("txfull");
    chk("txfull_ready_pulses", ready_cnt - r0, 2);
    chk("txfull_left", exp_wr.size(), 0);
    step();
    tx_al_empty = 1'b0;
    flush();
    tx_lim = 1000;

    // Reset during TX_ACCESS, then fresh burst
    for (int i = 1; i <= 5; i++) begin
      push_src(32'hF000_0000 + 32'(i));
      exp_wr.push_back(32'hF000_0000 + 32'(i));
    end
    exp_grant.push_back(2'b01);
    exp_grant.push_back(2'b01);
    tx_al_empty = 1'b1;
    ok = 0;
    for (int i = 0; i < 40 && ok == 0; i++) begin
      @(negedge pclk);
      if (m_penable && m_pwrite) ok = 1;
    end
    if (ok == 0) fail_now("rst_timeout");
    #1;
    preset = 1'b1;
    #1;
    chk("rst_penable", {31'd0, m_penable}, 32'd0);
    chk("rst_pwrite", {31'd0, m_pwrite}, 32'd0);
    chk("rst_paddr", m_paddr, 32'd0);
    chk("rst_pwdata", m_pwdata, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    step();
    step();
    preset = 1'b0;
    wait_quiet("rst_restart");
    step();
    tx_al_empty = 1'b0;

    chk("end_wr_left", exp_wr.size(), 0);
    chk("end_rx_left", exp_rx.size(), 0);
    chk("end_grant_left", exp_grant.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
